// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external integer ALU (add / addu / and) between two requesters.
//   Round-robin grant, valid/ready request handshake, one op in flight, and a
//   registered response held under backpressure. Flags signed overflow on add
//   and unsupported funct codes. Keeps a saturating completed-op count for each
//   requester.
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   reqN_valid/ready           request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_funct operands and funct code for requester N
//   alu_a, alu_b, alu_funct    drive the external ALU
//   alu_result                 combinational result back from the ALU
//   rsp_valid/ready            response handshake
//   rsp_data, rsp_id           result (0 on error) and issuing requester
//   rsp_ovf, rsp_err           signed add overflow / unsupported funct
//   cnt0, cnt1                 completed responses per requester, saturating
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [5:0]        req0_funct,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [5:0]        req1_funct,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [5:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_AND  = 6'b100100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nx;
  logic              rr_ptr;   // requester that wins when both are valid
  logic              gnt;      // requester granted this cycle
  logic              take;     // request handshake this cycle
  logic [DATA_W-1:0] op_a, op_b;
  logic [5:0]        op_funct;
  logic              op_id;
  logic              op_sup;
  logic              ovf_c;
  logic              rsp_take;

  always_comb begin
    state_nx   = state;
    gnt        = rr_ptr;
    take       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) gnt = rr_ptr;
        else                          gnt = req1_valid;
        take       = req0_valid | req1_valid;
        req0_ready = take & ~gnt;
        req1_ready = take & gnt;
        if (take) state_nx = EXEC;
      end
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign op_sup   = (op_funct == F_ADD) || (op_funct == F_ADDU) || (op_funct == F_AND);
  // Same-sign operands producing an opposite-sign sum; only meaningful for add.
  assign ovf_c    = (op_funct == F_ADD) && (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                    (alu_result[DATA_W-1] != op_a[DATA_W-1]);
  assign rsp_take = (state == RESP) && rsp_ready;

  // ALU inputs come straight from the op registers; an unsupported funct is
  // replaced by addu so the ALU only ever sees codes it implements.
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_funct = op_sup ? op_funct : F_ADDU;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_funct  <= F_ADDU;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
      cnt0      <= '0;
      cnt1      <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        op_a     <= gnt ? req1_a     : req0_a;
        op_b     <= gnt ? req1_b     : req0_b;
        op_funct <= gnt ? req1_funct : req0_funct;
        op_id    <= gnt;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_data  <= op_sup ? alu_result : '0;
        rsp_ovf   <= ovf_c;
        rsp_err   <= ~op_sup;
        rsp_id    <= op_id;
      end
      if (rsp_take) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= ~rsp_id;
        if (rsp_id) begin
          if (!(&cnt1)) cnt1 <= cnt1 + CNT_W'(1);
        end else begin
          if (!(&cnt0)) cnt0 <= cnt0 + CNT_W'(1);
        end
      end
    end
  end

endmodule
